// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: register index, hazard FSM states, control bundle.
// Pure declarations; no logic and no latency.
package pipe_pkg;

   typedef logic [4:0] reg_idx_t;
   localparam reg_idx_t REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_hold;
   } hz_ctrl_t;

   // Canonical control patterns, one per hazard-unit output case.
   localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam hz_ctrl_t CTRL_FAULT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam hz_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam hz_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam hz_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   function automatic logic reg_match(input reg_idx_t src, input logic used, input reg_idx_t dst);
      return used && (src == dst);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: ID sources against the load destination in EX.
// Zero latency, no state; x0 never hazards since it is never really written.
module load_use_detect
   import pipe_pkg::*;
#(
   parameter bit FWD_STORE_DATA = 1'b1
) (
   input  logic [4:0] IF_ID_Rs1,
   input  logic [4:0] IF_ID_Rs2,
   input  logic       IF_ID_UsesRs1,
   input  logic       IF_ID_UsesRs2,
   input  logic       IF_ID_IsStore,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] ID_EX_Rd,
   output logic       lu
);

   logic rs1_hit;
   logic rs2_hit;
   logic rs2_exempt;

   assign rs1_hit    = reg_match(IF_ID_Rs1, IF_ID_UsesRs1, ID_EX_Rd);
   assign rs2_hit    = reg_match(IF_ID_Rs2, IF_ID_UsesRs2, ID_EX_Rd);
   // Store data is consumed in MEM, late enough to be forwarded from the load.
   assign rs2_exempt = FWD_STORE_DATA && IF_ID_IsStore;

   assign lu = ID_EX_MemRead && (ID_EX_Rd != REG_ZERO)
               && (rs1_hit || (rs2_hit && !rs2_exempt));

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, memory-wait freeze with timeout, stall counter.
// Controls are combinational from state and inputs; state, wait count and Stall_Count update on clk.
module hazard_stall_unit
   import pipe_pkg::*;
#(
   parameter int MAX_WAIT       = 16,
   parameter int CNT_W          = 16,
   parameter bit FWD_STORE_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_Rs1,
   input  logic [4:0]       IF_ID_Rs2,
   input  logic             IF_ID_UsesRs1,
   input  logic             IF_ID_UsesRs2,
   input  logic             IF_ID_IsStore,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Rd,
   input  logic             EX_MEM_MemAccess,
   input  logic             Mem_Ready,
   input  logic             Flush,
   input  logic             Stall_Count_Clr,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Write,
   output logic             ID_EX_Bubble,
   output logic             EX_MEM_Hold,
   output logic             Mem_Timeout,
   output logic [CNT_W-1:0] Stall_Count
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   hz_state_t        state;
   logic [WW-1:0]    wait_cnt;
   logic [CNT_W-1:0] stall_cnt;
   hz_ctrl_t         ctrl;
   logic             lu;
   logic             freeze;
   logic             stall_cycle;

   load_use_detect #(
      .FWD_STORE_DATA (FWD_STORE_DATA)
   ) u_lu (
      .IF_ID_Rs1     (IF_ID_Rs1),
      .IF_ID_Rs2     (IF_ID_Rs2),
      .IF_ID_UsesRs1 (IF_ID_UsesRs1),
      .IF_ID_UsesRs2 (IF_ID_UsesRs2),
      .IF_ID_IsStore (IF_ID_IsStore),
      .ID_EX_MemRead (ID_EX_MemRead),
      .ID_EX_Rd      (ID_EX_Rd),
      .lu            (lu)
   );

   assign freeze = EX_MEM_MemAccess && !Mem_Ready;

   // A branch in EX is held during a freeze and re-asserts Flush once the pipe moves.
   always_comb begin
      ctrl = CTRL_RUN;
      if (!rst_n)
         ctrl = CTRL_RESET;
      else if (state == FAULT)
         ctrl = CTRL_FAULT;
      else if (freeze)
         ctrl = CTRL_FREEZE;
      else if (Flush)
         ctrl = CTRL_FLUSH;
      else if (lu)
         ctrl = CTRL_LU;
   end

   assign PC_Write     = ctrl.pc_write;
   assign IF_ID_Write  = ctrl.if_id_write;
   assign IF_ID_Flush  = ctrl.if_id_flush;
   assign ID_EX_Write  = ctrl.id_ex_write;
   assign ID_EX_Bubble = ctrl.id_ex_bubble;
   assign EX_MEM_Hold  = ctrl.ex_mem_hold;
   assign Mem_Timeout  = (state == FAULT);
   assign Stall_Count  = stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (freeze) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WW'(1);
               end
            end
            MEM_WAIT: begin
               if (!freeze) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_MAX) begin
                  state <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            FAULT:   state <= FAULT;
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   assign stall_cycle = (state != FAULT) && !ctrl.pc_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (Stall_Count_Clr)
         stall_cnt <= '0;
      else if (stall_cycle && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for combinational priorities,
// hand sequences for load-use, memory wait, timeout, saturation and async reset.
module tb_hazard_stall_unit;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, st, mr, acc, rdy, fl, clr;
   logic       pc_w, ifid_w, ifid_f, idex_w, bub, hold, tmo;
   logic [2:0] scnt;
   logic       lu_nofwd;

   int n_cmp = 0;
   int n_err = 0;

   // Expected control patterns: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Hold}
   localparam logic [5:0] E_RUN    = 6'b110100;
   localparam logic [5:0] E_FREEZE = 6'b000001;
   localparam logic [5:0] E_FAULT  = 6'b000001;
   localparam logic [5:0] E_FLUSH  = 6'b111110;
   localparam logic [5:0] E_LU     = 6'b000110;
   localparam logic [5:0] E_RESET  = 6'b000010;

   hazard_stall_unit #(.MAX_WAIT(4), .CNT_W(3), .FWD_STORE_DATA(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
      .IF_ID_IsStore(st), .ID_EX_MemRead(mr), .ID_EX_Rd(rd),
      .EX_MEM_MemAccess(acc), .Mem_Ready(rdy), .Flush(fl), .Stall_Count_Clr(clr),
      .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f), .ID_EX_Write(idex_w),
      .ID_EX_Bubble(bub), .EX_MEM_Hold(hold), .Mem_Timeout(tmo), .Stall_Count(scnt)
   );

   load_use_detect #(.FWD_STORE_DATA(1'b0)) u_nofwd (
      .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2), .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
      .IF_ID_IsStore(st), .ID_EX_MemRead(mr), .ID_EX_Rd(rd), .lu(lu_nofwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, st, mr, acc, rdy, fl;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [5:0] ctrl_now();
      return {pc_w, ifid_w, ifid_f, idex_w, bub, hold};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_ctrl(input string name, input logic [5:0] exp);
      logic [5:0] act;
      act = ctrl_now();
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: ctrl got %06b, expected %06b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; st = 0; mr = 0;
      acc = 0; rdy = 1; fl = 0; clr = 0;
   endtask

   task automatic set_lu();
      rs1 = 5'd5; u1 = 1; mr = 1; rd = 5'd5;
   endtask

   task automatic clr_cnt();
      @(negedge clk); idle(); clr = 1;
      @(negedge clk); clr = 0;
   endtask

   function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic a1,
                               input logic a2, input logic s, input logic m, input logic [4:0] d,
                               input logic ac, input logic ry, input logic f, input logic [5:0] e);
      vec_t v;
      v.rs1 = r1; v.rs2 = r2; v.u1 = a1; v.u2 = a2; v.st = s; v.mr = m; v.rd = d;
      v.acc = ac; v.rdy = ry; v.fl = f; v.exp = e;
      return v;
   endfunction

   initial begin
      //           rs1 rs2 u1 u2 st mr rd  acc rdy fl  expected
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN);
      vecs[1]  = mk(5, 0, 1, 0, 0, 1, 5, 0, 1, 0, E_LU);
      vecs[2]  = mk(0, 7, 0, 1, 0, 1, 7, 0, 1, 0, E_LU);
      vecs[3]  = mk(0, 7, 0, 1, 1, 1, 7, 0, 1, 0, E_RUN);
      vecs[4]  = mk(7, 0, 1, 0, 1, 1, 7, 0, 1, 0, E_LU);
      vecs[5]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, E_RUN);
      vecs[6]  = mk(5, 0, 0, 0, 0, 1, 5, 0, 1, 0, E_RUN);
      vecs[7]  = mk(5, 0, 1, 0, 0, 0, 5, 0, 1, 0, E_RUN);
      vecs[8]  = mk(4, 0, 1, 0, 0, 1, 5, 0, 1, 0, E_RUN);
      vecs[9]  = mk(5, 0, 1, 0, 0, 1, 5, 1, 0, 1, E_FREEZE);
      vecs[10] = mk(5, 0, 1, 0, 0, 1, 5, 1, 1, 1, E_FLUSH);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RUN);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_FREEZE);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_FLUSH);

      // Reset state
      idle(); rst_n = 0;
      #1;
      chk_ctrl("reset_ctrl", E_RESET);
      chk("reset_timeout", int'(tmo), 0);
      chk("reset_count", int'(scnt), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      chk_ctrl("post_reset_run", E_RUN);

      // Combinational priority table
      foreach (vecs[i]) begin
         @(negedge clk);
         rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
         st = vecs[i].st; mr = vecs[i].mr; rd = vecs[i].rd;
         acc = vecs[i].acc; rdy = vecs[i].rdy; fl = vecs[i].fl;
         #1;
         chk_ctrl($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Store-data exemption disabled: rs2 match on a store stalls
      @(negedge clk); idle();
      rs2 = 5'd7; u2 = 1; st = 1; mr = 1; rd = 5'd7;
      #1;
      chk("nofwd_store_lu", int'(lu_nofwd), 1);
      chk_ctrl("fwd_store_no_stall", E_RUN);

      // Load-use single bubble
      clr_cnt();
      @(negedge clk); set_lu();
      #1;
      chk_ctrl("lu_bubble", E_LU);
      @(negedge clk); mr = 0;
      #1;
      chk_ctrl("lu_release", E_RUN);
      chk("lu_count", int'(scnt), 1);

      // Memory wait for 3 cycles
      clr_cnt();
      @(negedge clk); acc = 1; rdy = 0;
      #1;
      chk_ctrl("mw_freeze0", E_FREEZE);
      chk("mw_wait0", int'(dut.wait_cnt), 0);
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("mw_wait%0d", k), int'(dut.wait_cnt), k);
         chk_ctrl($sformatf("mw_freeze%0d", k), E_FREEZE);
      end
      chk("mw_state", int'(dut.state), 1);
      @(negedge clk);
      chk("mw_wait3", int'(dut.wait_cnt), 3);
      rdy = 1;
      #1;
      chk_ctrl("mw_ready", E_RUN);
      @(negedge clk); acc = 0;
      #1;
      chk("mw_wait_back", int'(dut.wait_cnt), 0);
      chk("mw_state_run", int'(dut.state), 0);
      chk("mw_count", int'(scnt), 3);

      // Timeout: MAX_WAIT=4, fault visible after the 5th frozen edge
      clr_cnt();
      @(negedge clk); acc = 1; rdy = 0;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         #1;
         chk($sformatf("to_flag_e%0d", e), int'(tmo), (e >= 5) ? 1 : 0);
      end
      chk("to_count", int'(scnt), 5);
      chk_ctrl("to_ctrl", E_FAULT);
      @(negedge clk); acc = 0; rdy = 1; fl = 1; set_lu();
      #1;
      chk_ctrl("to_sticky_ctrl", E_FAULT);
      chk("to_sticky_flag", int'(tmo), 1);
      #1;
      rst_n = 0;
      #1;
      chk("arst_timeout", int'(tmo), 0);
      chk("arst_state", int'(dut.state), 0);
      chk("arst_count", int'(scnt), 0);
      chk_ctrl("arst_ctrl", E_RESET);
      @(negedge clk); idle(); rst_n = 1;

      // Saturation at 7 and clear priority
      @(negedge clk); set_lu();
      repeat (9) @(negedge clk);
      #1;
      chk("sat_count", int'(scnt), 7);
      clr = 1;
      @(negedge clk);
      #1;
      chk("clr_over_inc", int'(scnt), 0);
      clr = 0; idle();
      @(negedge clk);
      #1;
      chk("idle_after_clr", int'(scnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
